// File: rtl/nw_cell_sequencer.sv
// nw_cell_sequencer
//   Generates the (i, j) cell address stream that fills the Needleman-Wunsch
//   score matrix. Two traversal orders are supported:
//     mode = 0 : row-major (sequential fill)
//     mode = 1 : anti-diagonal wavefront. Cells on one diagonal do not depend
//                on each other.
//   Row 0 and column 0 are pre-initialised and are skipped because every
//   index starts at START. A start/busy/done handshake talks to the RAM
//   control FSM.
//
// Parameters
//   ROWS, COLS : matrix dimensions. i runs START..ROWS-1, j runs START..COLS-1.
//   START      : first row/column index visited. Must be < ROWS and < COLS.
//
// Ports
//   clk          : system clock
//   rst          : synchronous active-high reset. It aborts a traversal and
//                  no done pulse follows.
//   start        : begin a traversal. Sampled in IDLE only.
//   mode         : traversal order. Latched when start is accepted.
//   en           : step enable (RAM read/write window open)
//   change_index : advance to the next cell. Effective only when en=1.
//   i, j         : current cell. Valid while busy. Holds the final cell
//                  after the traversal ends.
//   busy         : traversal in progress
//   last         : busy and the current cell is (ROWS-1, COLS-1)
//   done         : one-cycle pulse after the final cell is consumed
//   cell_cnt     : count of consumed cells. Present only with CELL_COUNT_EN.
//
// Optional feature macro: CELL_COUNT_EN (adds the cell_cnt progress counter)

module nw_cell_sequencer #(
    parameter int ROWS  = 128,
    parameter int COLS  = 128,
    parameter int START = 1,
    localparam int IW   = $clog2(ROWS) + 1,
    localparam int JW   = $clog2(COLS) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    input  logic          en,
    input  logic          change_index,
    output logic [IW-1:0] i,
    output logic [JW-1:0] j,
    output logic          busy,
    output logic          last,
    output logic          done
`ifdef CELL_COUNT_EN
    ,
    output logic [$clog2(ROWS*COLS):0] cell_cnt
`endif
);

    // The diagonal sum d+1 can reach ROWS+COLS-2. One extra bit above the
    // wider index keeps that sum from overflowing.
    localparam int DW = ((IW > JW) ? IW : JW) + 1;

    localparam logic [IW-1:0] I_FIRST = IW'(START);
    localparam logic [IW-1:0] I_LAST  = IW'(ROWS - 1);
    localparam logic [JW-1:0] J_FIRST = JW'(START);
    localparam logic [JW-1:0] J_LAST  = JW'(COLS - 1);
    localparam logic [DW-1:0] D_FIRST = DW'(START);
    localparam logic [DW-1:0] D_JLAST = DW'(COLS - 1);
    // When d+1 >= START+COLS-1, the first cell of the next diagonal lies on
    // the last column instead of on row START.
    localparam logic [DW-1:0] D_SPLIT = DW'(START + COLS - 1);

    generate
        if (START >= ROWS || START >= COLS) begin : g_bad_start
            $error("nw_cell_sequencer: START must be below ROWS and COLS");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] i_nxt, step_i;
    logic [JW-1:0] j_nxt, step_j;
    logic          mode_q, mode_nxt;
    logic          at_last;
    logic [DW-1:0] d_next, i_diag, j_diag;

    assign at_last = (i == I_LAST) && (j == J_LAST);
    assign last    = busy && at_last;

    // The next diagonal starts at the cell with the smallest legal i.
    // Subtracting the column limit first, and doing it only when the result
    // is >= START, keeps the arithmetic unsigned.
    assign d_next = DW'(i) + DW'(j) + DW'(1);
    assign i_diag = (d_next >= D_SPLIT) ? (d_next - D_JLAST) : D_FIRST;
    assign j_diag = d_next - i_diag;

    // Successor of the current cell for the latched mode. Only used when the
    // current cell is not the final one.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves a variable unassigned and no latch is inferred.
        step_i = i;
        step_j = j;
        if (!mode_q) begin
            if (j == J_LAST) begin
                step_i = i + IW'(1);
                step_j = J_FIRST;
            end else begin
                step_j = j + JW'(1);
            end
        end else begin
            if (i < I_LAST && j > J_FIRST) begin
                step_i = i + IW'(1);
                step_j = j - JW'(1);
            end else begin
                step_i = IW'(i_diag);
                step_j = JW'(j_diag);
            end
        end
    end

    // Next-state and output logic
    always_comb begin
        state_nxt = state;
        i_nxt     = i;
        j_nxt     = j;
        mode_nxt  = mode_q;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    i_nxt     = I_FIRST;
                    j_nxt     = J_FIRST;
                    mode_nxt  = mode;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (en && change_index) begin
                    if (at_last) begin
                        state_nxt = DONE;
                    end else begin
                        i_nxt = step_i;
                        j_nxt = step_j;
                    end
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register samples values from before the edge. The result then does
        // not depend on process ordering.
        if (rst) begin
            state  <= IDLE;
            i      <= '0;
            j      <= '0;
            mode_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            i      <= i_nxt;
            j      <= j_nxt;
            mode_q <= mode_nxt;
        end
    end

`ifdef CELL_COUNT_EN
    localparam int CW = $clog2(ROWS*COLS) + 1;

    // Counts every advance, including the final one. It holds through DONE
    // and IDLE, so software can read the completed total.
    always_ff @(posedge clk) begin
        if (rst) begin
            cell_cnt <= '0;
        end else if (state == IDLE && start) begin
            cell_cnt <= '0;
        end else if (busy && en && change_index) begin
            cell_cnt <= cell_cnt + CW'(1);
        end
    end
`endif

endmodule
